uc_secuencial: RTL and testbench
================================

Name: uc_secuencial

Overview:
- Sequencing control unit that drives the single-cycle CPU datapath.
- Consumes the datapath's 6-bit opcode and zero flag, and produces every datapath control strobe.
- Adds multi-cycle behaviour the datapath cannot provide alone: a valid/ack handshake for the input-port load, a bounded wait timeout, a HALT state with resume, and a retired-instruction counter.
- Requires the datapath program counter to gain an enable input, driven by pc_en.

Parameters:
- IN_TIMEOUT, 255: cycles to wait for in_valid before abandoning a LOAD_IN. 0 disables the timeout (wait forever).
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  6  instruction[31:26] from the datapath.
- z  in  1  registered zero flag from the datapath.
- in_valid  in  1  input device has data on Datos.
- run  in  1  resume pulse while HALTED.
- s_inc  out  1  1 = PC+1, 0 = PC <- instruction[9:0].
- s_mux_alu  out  1  1 = immediate instruction[15:0] as ALU operand A, 0 = rd1.
- s_mux_datos  out  1  1 = write Datos to regfile, 0 = ALU result.
- we3  out  1  regfile write enable.
- wez  out  1  zero-flag write enable.
- op_alu  out  3  ALU operation.
- pc_en  out  1  PC register load enable.
- in_ack  out  1  handshake acknowledge, one cycle.
- halted  out  1  unit is in HALTED.
- in_timeout  out  1  sticky; set when a LOAD_IN timed out.
- retired  out  CNT_W  count of cycles with pc_en=1.

Behaviour:
- Opcode decode:
  - 00_0ooo: ALU reg-reg. op_alu=ooo, s_mux_alu=0, s_mux_datos=0, we3=1, wez=1, s_inc=1.
  - 00_1ooo: as above but s_mux_alu=1.
  - 01_0000: LOAD_IN.
  - 10_0000: J, s_inc=0.
  - 10_0001: JZ, s_inc=~z.
  - 10_0010: JNZ, s_inc=z.
  - 11_1111: HALT.
  - All other opcodes: NOP (s_inc=1, we3=wez=0).
- Defaults when not stated otherwise: op_alu=000, s_mux_alu=0, s_mux_datos=0, we3=0, wez=0, in_ack=0, s_inc=1, pc_en=1.
- Outputs are combinational from the registered state plus opcode/z/in_valid (Mealy). State, counters and flags are registered.
- States: RUN, WAIT_IN, HALTED.
- RUN, non-LOAD_IN/HALT opcode: execute in 1 cycle with pc_en=1.
- RUN, LOAD_IN, in_valid=1: same cycle we3=1, s_mux_datos=1, in_ack=1, pc_en=1; stay RUN.
- RUN, LOAD_IN, in_valid=0: pc_en=0, we3=0; next state WAIT_IN; wait counter <- 0.
- WAIT_IN, in_valid=1: we3=1, s_mux_datos=1, in_ack=1, pc_en=1; next state RUN.
- WAIT_IN, in_valid=0:
  - pc_en=0; wait counter increments.
  - If IN_TIMEOUT!=0 and counter==IN_TIMEOUT-1: pc_en=1, we3=0, in_ack=0, in_timeout<=1; next state RUN.
  - in_valid takes priority over timeout in the same cycle.
- RUN, HALT: pc_en=0, no writes; next state HALTED.
- HALTED: halted=1, pc_en=0, no writes.
  - run=1: pc_en=1, s_inc=1 (PC advances past HALT); next state RUN.
  - run in any other state is ignored.
- retired increments on every cycle with pc_en=1 and wraps modulo 2^CNT_W.
- in_timeout is cleared only by reset.
- Reset (synchronous, active-high):
  - state=RUN, wait counter=0, retired=0, in_timeout=0.
  - While reset=1: pc_en=we3=wez=in_ack=0, halted=0.
  - Reset asserted in WAIT_IN or HALTED aborts to RUN with no ack and no write.

Test Plan:
- Reset, then program ALU reg-reg (opcode 000010), imm (001011), NOP (010101) -> per-cycle outputs match decode table; pc_en=1 each cycle; retired=3.
- JZ (100001) with z=1 -> s_inc=0; with z=0 -> s_inc=1. JNZ (100010) mirrored. J (100000) -> s_inc=0 regardless of z.
- LOAD_IN with in_valid raised after 5 cycles -> pc_en=0 for 5 cycles; on the 6th cycle we3=1, s_mux_datos=1, in_ack=1 for exactly 1 cycle; retired +1. LOAD_IN with in_valid already high -> completes in 1 cycle.
- IN_TIMEOUT=4, LOAD_IN, in_valid held 0 -> on the 5th cycle pc_en=1, we3=0, in_timeout=1 stays set. in_valid=1 exactly on the timeout cycle -> ack and write, no timeout.
- HALT -> halted=1 from the next cycle, pc_en=0; run pulse -> pc_en=1 that cycle, then RUN. Reset mid-HALTED and mid-WAIT_IN -> RUN, counters and flags 0, no in_ack.
- CNT_W=4: 17 retired cycles -> retired=1 (wrap).

Source files
------------

// File: rtl/uc_secuencial.sv
// Sequencing control unit for the single-cycle CPU datapath: decodes the opcode into
// datapath strobes and adds the input-port handshake, bounded wait, HALT/resume and retired count.
module uc_secuencial #(
  parameter int unsigned IN_TIMEOUT = 255,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             z,
  input  logic             in_valid,
  input  logic             run,
  output logic             s_inc,
  output logic             s_mux_alu,
  output logic             s_mux_datos,
  output logic             we3,
  output logic             wez,
  output logic [2:0]       op_alu,
  output logic             pc_en,
  output logic             in_ack,
  output logic             halted,
  output logic             in_timeout,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned WAIT_W  = (IN_TIMEOUT > 1) ? $clog2(IN_TIMEOUT) : 1;
  localparam int unsigned TO_LAST = (IN_TIMEOUT == 0) ? 0 : IN_TIMEOUT - 1;
  localparam bit          TO_EN   = (IN_TIMEOUT != 0);

  localparam logic [5:0] OP_LOAD_IN = 6'b01_0000;
  localparam logic [5:0] OP_J       = 6'b10_0000;
  localparam logic [5:0] OP_JZ      = 6'b10_0001;
  localparam logic [5:0] OP_JNZ     = 6'b10_0010;
  localparam logic [5:0] OP_HALT    = 6'b11_1111;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_WAIT_IN = 2'd1,
    ST_HALTED  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [CNT_W-1:0]    r_retired;
  logic                r_in_timeout;
  logic                w_timeout;
  logic                w_load_stall;

  // Input device never answered within the allowed window; in_valid wins if it arrives now.
  assign w_timeout    = TO_EN && (r_state == ST_WAIT_IN) && !in_valid &&
                        (r_wait_cnt == WAIT_W'(TO_LAST));
  assign w_load_stall = (r_state == ST_RUN) && (opcode == OP_LOAD_IN) && !in_valid;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_load_stall)            w_state_nxt = ST_WAIT_IN;
        else if (opcode == OP_HALT)  w_state_nxt = ST_HALTED;
      end
      ST_WAIT_IN: begin
        if (in_valid || w_timeout)   w_state_nxt = ST_RUN;
      end
      ST_HALTED: begin
        if (run)                     w_state_nxt = ST_RUN;
      end
      default:                       w_state_nxt = ST_RUN;
    endcase
  end

  // Mealy output decode; reset forces a quiet, non-advancing datapath
  always_comb begin
    s_inc       = 1'b1;
    s_mux_alu   = 1'b0;
    s_mux_datos = 1'b0;
    we3         = 1'b0;
    wez         = 1'b0;
    op_alu      = 3'b000;
    pc_en       = 1'b1;
    in_ack      = 1'b0;
    halted      = 1'b0;
    if (reset) begin
      pc_en = 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (opcode[5:4] == 2'b00) begin
            op_alu    = opcode[2:0];
            s_mux_alu = opcode[3];
            we3       = 1'b1;
            wez       = 1'b1;
          end else begin
            case (opcode)
              OP_LOAD_IN: begin
                if (in_valid) begin
                  we3         = 1'b1;
                  s_mux_datos = 1'b1;
                  in_ack      = 1'b1;
                end else begin
                  pc_en = 1'b0;
                end
              end
              OP_J:    s_inc = 1'b0;
              OP_JZ:   s_inc = ~z;
              OP_JNZ:  s_inc = z;
              OP_HALT: pc_en = 1'b0;
              default: ;
            endcase
          end
        end
        ST_WAIT_IN: begin
          if (in_valid) begin
            we3         = 1'b1;
            s_mux_datos = 1'b1;
            in_ack      = 1'b1;
          end else if (!w_timeout) begin
            pc_en = 1'b0;
          end
        end
        ST_HALTED: begin
          halted = 1'b1;
          pc_en  = run;
        end
        default: pc_en = 1'b0;
      endcase
    end
  end

  // Wait counter, sticky timeout flag and retired-instruction counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt   <= '0;
      r_retired    <= '0;
      r_in_timeout <= 1'b0;
    end else begin
      if (w_load_stall)
        r_wait_cnt <= '0;
      else if ((r_state == ST_WAIT_IN) && !in_valid)
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      if (pc_en)
        r_retired <= r_retired + CNT_W'(1);
      if (w_timeout)
        r_in_timeout <= 1'b1;
    end
  end

  assign in_timeout = r_in_timeout;
  assign retired    = r_retired;

endmodule

// File: tb/tb_uc_secuencial.sv
// Directed bench for uc_secuencial: expected strobe vectors are queued as each cycle is
// driven and popped/compared once the Mealy outputs settle.
module tb_uc_secuencial;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       z;
  logic       in_valid;
  logic       run;

  logic        a_s_inc, a_s_mux_alu, a_s_mux_datos, a_we3, a_wez, a_pc_en, a_in_ack, a_halted, a_in_timeout;
  logic [2:0]  a_op_alu;
  logic [15:0] a_retired;
  logic        b_s_inc, b_s_mux_alu, b_s_mux_datos, b_we3, b_wez, b_pc_en, b_in_ack, b_halted, b_in_timeout;
  logic [2:0]  b_op_alu;
  logic [3:0]  b_retired;

  // Default parameters: long timeout, 16-bit counter
  uc_secuencial #(.IN_TIMEOUT(255), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .opcode(opcode), .z(z), .in_valid(in_valid), .run(run),
    .s_inc(a_s_inc), .s_mux_alu(a_s_mux_alu), .s_mux_datos(a_s_mux_datos), .we3(a_we3),
    .wez(a_wez), .op_alu(a_op_alu), .pc_en(a_pc_en), .in_ack(a_in_ack), .halted(a_halted),
    .in_timeout(a_in_timeout), .retired(a_retired)
  );

  // Short timeout and narrow counter for the timeout and wrap cases
  uc_secuencial #(.IN_TIMEOUT(4), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .opcode(opcode), .z(z), .in_valid(in_valid), .run(run),
    .s_inc(b_s_inc), .s_mux_alu(b_s_mux_alu), .s_mux_datos(b_s_mux_datos), .we3(b_we3),
    .wez(b_wez), .op_alu(b_op_alu), .pc_en(b_pc_en), .in_ack(b_in_ack), .halted(b_halted),
    .in_timeout(b_in_timeout), .retired(b_retired)
  );

  logic [10:0] ctl_a, ctl_b;
  assign ctl_a = {a_s_inc, a_s_mux_alu, a_s_mux_datos, a_we3, a_wez, a_op_alu, a_pc_en, a_in_ack, a_halted};
  assign ctl_b = {b_s_inc, b_s_mux_alu, b_s_mux_datos, b_we3, b_wez, b_op_alu, b_pc_en, b_in_ack, b_halted};

  localparam logic [5:0] NOP  = 6'b01_0101;
  localparam logic [5:0] LDI  = 6'b01_0000;
  localparam logic [5:0] JMP  = 6'b10_0000;
  localparam logic [5:0] JZ   = 6'b10_0001;
  localparam logic [5:0] JNZ  = 6'b10_0010;
  localparam logic [5:0] HALT = 6'b11_1111;

  logic [10:0] exp_q[$];
  string       tag_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          use_b    = 1'b0;

  logic [10:0] d_stall, d_nop, d_load, d_halted, d_resume, d_jump;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] mk(input logic si, input logic sa, input logic sd, input logic w3,
                                     input logic wz, input logic [2:0] op, input logic pe,
                                     input logic ack, input logic h);
    return {si, sa, sd, w3, wz, op, pe, ack, h};
  endfunction

  task automatic compare_front();
    logic [10:0] e;
    logic [10:0] obs;
    string       t;
    e   = exp_q.pop_front();
    t   = tag_q.pop_front();
    obs = use_b ? ctl_b : ctl_a;
    n_checks++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", t, obs, e);
    end
  endtask

  // One clock cycle: drive inputs, queue the expectation, compare once outputs settle
  task automatic step(input logic rst, input logic [5:0] opc, input logic zz, input logic iv,
                      input logic rn, input logic [10:0] e, input string tag);
    reset    = rst;
    opcode   = opc;
    z        = zz;
    in_valid = iv;
    run      = rn;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #2;
    compare_front();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] e);
    n_checks++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
    end
  endtask

  initial begin
    d_stall  = mk(1, 0, 0, 0, 0, 3'b000, 0, 0, 0);
    d_nop    = mk(1, 0, 0, 0, 0, 3'b000, 1, 0, 0);
    d_load   = mk(1, 0, 1, 1, 0, 3'b000, 1, 1, 0);
    d_halted = mk(1, 0, 0, 0, 0, 3'b000, 0, 0, 1);
    d_resume = mk(1, 0, 0, 0, 0, 3'b000, 1, 0, 1);
    d_jump   = mk(0, 0, 0, 0, 0, 3'b000, 1, 0, 0);

    reset = 1'b1; opcode = NOP; z = 1'b0; in_valid = 1'b0; run = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    step(1, NOP, 0, 0, 0, d_stall, "reset_outputs");
    check_val("reset_retired", a_retired, 16'd0);
    check_val("reset_in_timeout", 16'(a_in_timeout), 16'd0);

    // Decode: reg-reg, immediate, NOP
    step(0, 6'b00_0010, 0, 0, 0, mk(1, 0, 0, 1, 1, 3'b010, 1, 0, 0), "alu_rr");
    step(0, 6'b00_1011, 0, 0, 0, mk(1, 1, 0, 1, 1, 3'b011, 1, 0, 0), "alu_imm");
    step(0, NOP,        0, 0, 0, d_nop, "nop");
    check_val("retired_after_3", a_retired, 16'd3);

    // Branches
    step(0, JZ,  1, 0, 0, d_jump, "jz_taken");
    step(0, JZ,  0, 0, 0, d_nop,  "jz_not_taken");
    step(0, JNZ, 0, 0, 0, d_jump, "jnz_taken");
    step(0, JNZ, 1, 0, 0, d_nop,  "jnz_not_taken");
    step(0, JMP, 0, 0, 0, d_jump, "j_z0");
    step(0, JMP, 1, 0, 0, d_jump, "j_z1");
    check_val("retired_after_jumps", a_retired, 16'd9);

    // LOAD_IN, data arrives after 5 stalled cycles
    for (int i = 0; i < 5; i++) step(0, LDI, 0, 0, 0, d_stall, "ldi_wait");
    check_val("retired_during_wait", a_retired, 16'd9);
    step(0, LDI, 0, 1, 0, d_load, "ldi_ack");
    check_val("retired_after_ldi", a_retired, 16'd10);
    step(0, NOP, 0, 0, 0, d_nop, "ack_single_cycle");

    // LOAD_IN with data already present
    step(0, LDI, 0, 1, 0, d_load, "ldi_immediate");
    check_val("retired_after_ldi_imm", a_retired, 16'd12);

    // HALT and resume
    step(0, HALT, 0, 0, 0, d_stall,  "halt_enter");
    step(0, HALT, 0, 0, 0, d_halted, "halted_hold");
    step(0, HALT, 0, 0, 1, d_resume, "halted_resume");
    step(0, NOP,  0, 0, 0, d_nop,    "after_resume");
    check_val("retired_after_halt", a_retired, 16'd14);
    step(0, NOP,  0, 0, 1, d_nop,    "run_ignored_in_run");

    // Reset while HALTED
    step(0, HALT, 0, 0, 0, d_stall,  "halt2_enter");
    step(0, HALT, 0, 0, 0, d_halted, "halted2_hold");
    step(1, HALT, 0, 0, 1, d_stall,  "rst_in_halted");
    check_val("retired_rst_halted", a_retired, 16'd0);
    step(0, NOP,  0, 0, 0, d_nop,    "post_rst_halted");

    // Reset while WAIT_IN, with in_valid arriving during reset
    step(0, LDI, 0, 0, 0, d_stall, "ldi2_enter");
    step(0, LDI, 0, 0, 0, d_stall, "ldi2_wait");
    step(1, LDI, 0, 1, 0, d_stall, "rst_in_wait");
    check_val("retired_rst_wait", a_retired, 16'd0);
    step(0, NOP, 0, 0, 0, d_nop,   "post_rst_wait");

    // Timeout instance
    use_b = 1'b1;
    step(1, NOP, 0, 0, 0, d_stall, "b_reset");
    for (int i = 0; i < 4; i++) step(0, LDI, 0, 0, 0, d_stall, "to_wait");
    step(0, LDI, 0, 0, 0, d_nop, "to_expire");
    check_val("to_flag_set", 16'(b_in_timeout), 16'd1);
    check_val("to_retired", 16'(b_retired), 16'd1);
    step(0, NOP, 0, 0, 0, d_nop, "to_after");
    check_val("to_flag_sticky", 16'(b_in_timeout), 16'd1);

    // in_valid exactly on the timeout cycle wins
    step(1, NOP, 0, 0, 0, d_stall, "b_reset2");
    check_val("to_flag_cleared", 16'(b_in_timeout), 16'd0);
    for (int i = 0; i < 4; i++) step(0, LDI, 0, 0, 0, d_stall, "to2_wait");
    step(0, LDI, 0, 1, 0, d_load, "to2_valid_wins");
    check_val("to2_no_flag", 16'(b_in_timeout), 16'd0);

    // 4-bit retired counter wraps after 16
    step(1, NOP, 0, 0, 0, d_stall, "b_reset3");
    for (int i = 0; i < 17; i++) step(0, NOP, 0, 0, 0, d_nop, "wrap_nop");
    check_val("retired_wrap", 16'(b_retired), 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
